// File: rtl/irq_nmi_seq.sv
// irq_nmi_seq: interrupt/reset request sequencer feeding the CPU control unit.
// Synchronizes /NMI and /IRQ, latches the NMI falling edge, arbitrates
// RESET > NMI > IRQ at instruction boundaries and holds one registered
// request (type, vector, pushed B) until the control unit acknowledges it.
module irq_nmi_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int RESET_DELAY = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        P_I,
  input  logic        insn_boundary,
  input  logic        int_ack,
  output logic        int_pending,
  output logic [1:0]  int_type,
  output logic [15:0] vector_addr,
  output logic        push_B,
  output logic        nmi_latch
);

  typedef enum logic [1:0] {
    RST_WAIT  = 2'd0,
    IDLE      = 2'd1,
    PRESENTED = 2'd2
  } state_t;

  localparam logic [1:0]  TYPE_NONE  = 2'b00;
  localparam logic [1:0]  TYPE_IRQ   = 2'b01;
  localparam logic [1:0]  TYPE_NMI   = 2'b10;
  localparam logic [1:0]  TYPE_RESET = 2'b11;
  localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
  localparam logic [15:0] VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] VEC_RESET  = 16'hFFFC;
  localparam logic [7:0]  DELAY_CNT  = RESET_DELAY[7:0];

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] nmi_sync_reg;
  logic [SYNC_STAGES-1:0] irq_sync_reg;
  logic                   nmi_prev_reg;
  logic                   nmi_latch_reg;
  logic                   rst_req_reg;
  logic [7:0]             reset_cnt_reg;
  logic                   int_pending_reg;
  logic [1:0]             int_type_reg;
  logic [15:0]            vector_addr_reg;

  logic nmi_s;
  logic irq_s;
  logic nmi_edge;
  logic irq_active;
  logic nmi_ack;

  assign nmi_s      = nmi_sync_reg[SYNC_STAGES-1];
  assign irq_s      = irq_sync_reg[SYNC_STAGES-1];
  // Falling edge seen at the synchronizer output; held-low levels do not retrigger.
  assign nmi_edge   = nmi_prev_reg & ~nmi_s;
  // IRQ is a level: only honoured while the pin is still low at the boundary.
  assign irq_active = ~irq_s & ~P_I;
  assign nmi_ack    = int_ack & (state_reg == PRESENTED) & (int_type_reg == TYPE_NMI);

  // Pin synchronizer chains; idle-high so reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_sync_reg <= '1;
      irq_sync_reg <= '1;
      nmi_prev_reg <= 1'b1;
    end else begin
      nmi_sync_reg <= {nmi_sync_reg[SYNC_STAGES-2:0], nmi_n};
      irq_sync_reg <= {irq_sync_reg[SYNC_STAGES-2:0], irq_n};
      nmi_prev_reg <= nmi_s;
    end
  end

  // NMI edge latch: a new edge in the ack cycle wins so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_latch_reg <= 1'b0;
    end else if (nmi_edge) begin
      nmi_latch_reg <= 1'b1;
    end else if (nmi_ack) begin
      nmi_latch_reg <= 1'b0;
    end
  end

  // Request FSM: reset countdown, idle arbitration, hold until acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= RST_WAIT;
      rst_req_reg     <= 1'b1;
      reset_cnt_reg   <= 8'd0;
      int_pending_reg <= 1'b0;
      int_type_reg    <= TYPE_NONE;
      vector_addr_reg <= VEC_IRQ;
    end else begin
      case (state_reg)
        RST_WAIT: begin
          if (reset_cnt_reg == DELAY_CNT) begin
            state_reg       <= PRESENTED;
            int_pending_reg <= 1'b1;
            int_type_reg    <= TYPE_RESET;
            vector_addr_reg <= VEC_RESET;
          end else begin
            reset_cnt_reg <= reset_cnt_reg + 8'd1;
          end
        end
        IDLE: begin
          if (insn_boundary && !rst_req_reg) begin
            if (nmi_latch_reg) begin
              state_reg       <= PRESENTED;
              int_pending_reg <= 1'b1;
              int_type_reg    <= TYPE_NMI;
              vector_addr_reg <= VEC_NMI;
            end else if (irq_active) begin
              state_reg       <= PRESENTED;
              int_pending_reg <= 1'b1;
              int_type_reg    <= TYPE_IRQ;
              vector_addr_reg <= VEC_IRQ;
            end
          end
        end
        PRESENTED: begin
          // Presented request is frozen; no preemption by later arrivals.
          if (int_ack) begin
            if (int_type_reg == TYPE_RESET) begin
              rst_req_reg <= 1'b0;
            end
            state_reg       <= IDLE;
            int_pending_reg <= 1'b0;
            int_type_reg    <= TYPE_NONE;
            vector_addr_reg <= VEC_IRQ;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign int_pending = int_pending_reg;
  assign int_type    = int_type_reg;
  assign vector_addr = vector_addr_reg;
  assign push_B      = 1'b0;
  assign nmi_latch   = nmi_latch_reg;

endmodule

// File: tb/tb_irq_nmi_seq.sv
// Directed bench for irq_nmi_seq: table of per-cycle vectors plus a
// hand-written async-reset-mid-request sequence.
module tb_irq_nmi_seq;

  localparam int RESET_DELAY = 7;

  logic        clk;
  logic        rst;
  logic        nmi_n;
  logic        irq_n;
  logic        P_I;
  logic        insn_boundary;
  logic        int_ack;
  logic        int_pending;
  logic [1:0]  int_type;
  logic [15:0] vector_addr;
  logic        push_B;
  logic        nmi_latch;

  int total;
  int bad;

  typedef struct {
    logic       nmi_n;
    logic       irq_n;
    logic       p_i;
    logic       bnd;
    logic       ack;
    logic       exp_pend;
    logic [1:0] exp_type;
    logic       exp_latch;
  } vec_t;

  vec_t vecs[$];

  irq_nmi_seq #(
    .SYNC_STAGES(2),
    .RESET_DELAY(RESET_DELAY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .nmi_n        (nmi_n),
    .irq_n        (irq_n),
    .P_I          (P_I),
    .insn_boundary(insn_boundary),
    .int_ack      (int_ack),
    .int_pending  (int_pending),
    .int_type     (int_type),
    .vector_addr  (vector_addr),
    .push_B       (push_B),
    .nmi_latch    (nmi_latch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] vec_of(input logic [1:0] t);
    case (t)
      2'b11:   return 16'hFFFC;
      2'b10:   return 16'hFFFA;
      default: return 16'hFFFE;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic pend, input logic [1:0] typ, input logic lat);
    chk({tag, ".pending"}, {15'd0, int_pending}, {15'd0, pend});
    chk({tag, ".type"}, {14'd0, int_type}, {14'd0, typ});
    chk({tag, ".vector"}, vector_addr, vec_of(typ));
    chk({tag, ".latch"}, {15'd0, nmi_latch}, {15'd0, lat});
    chk({tag, ".push_B"}, {15'd0, push_B}, 16'd0);
  endtask

  task automatic add(input logic nn, input logic in, input logic pi, input logic b,
                     input logic a, input logic ep, input logic [1:0] et, input logic el);
    vec_t v;
    v.nmi_n = nn; v.irq_n = in; v.p_i = pi; v.bnd = b; v.ack = a;
    v.exp_pend = ep; v.exp_type = et; v.exp_latch = el;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    nmi_n = 1'b1; irq_n = 1'b1; P_I = 1'b1; insn_boundary = 1'b0; int_ack = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // Row n corresponds to edge n after rst release; inputs applied before that edge.
    //   nmi irq pi bnd ack | pend type latch
    for (int i = 1; i <= 7; i++) add(1, 1, 1, 0, 0, 0, 2'b00, 0);   // 1-7 reset countdown
    add(1, 1, 1, 0, 0, 1, 2'b11, 0);                                  // 8  RESET presented
    add(1, 1, 1, 0, 1, 0, 2'b00, 0);                                  // 9  ack RESET
    add(0, 1, 1, 0, 0, 0, 2'b00, 0);                                  // 10 nmi falls
    add(0, 1, 1, 0, 0, 0, 2'b00, 0);                                  // 11
    add(0, 1, 1, 0, 0, 0, 2'b00, 1);                                  // 12 latch set
    add(0, 1, 1, 0, 0, 0, 2'b00, 1);                                  // 13
    add(0, 1, 1, 1, 0, 1, 2'b10, 1);                                  // 14 NMI presented
    add(0, 1, 1, 0, 1, 0, 2'b00, 0);                                  // 15 ack NMI
    for (int i = 16; i <= 19; i++) add(0, 1, 1, 0, 0, 0, 2'b00, 0);  // 16-19 held low
    add(0, 1, 1, 1, 0, 0, 2'b00, 0);                                  // 20 boundary, no new edge
    add(1, 1, 1, 0, 0, 0, 2'b00, 0);                                  // 21
    add(1, 0, 1, 0, 0, 0, 2'b00, 0);                                  // 22 irq low, masked
    add(1, 0, 1, 0, 0, 0, 2'b00, 0);                                  // 23
    add(1, 0, 1, 1, 0, 0, 2'b00, 0);                                  // 24 masked boundary
    add(1, 0, 0, 1, 0, 1, 2'b01, 0);                                  // 25 IRQ presented
    add(1, 1, 0, 0, 0, 1, 2'b01, 0);                                  // 26 irq withdrawn
    add(1, 1, 0, 0, 0, 1, 2'b01, 0);                                  // 27
    add(1, 1, 0, 0, 0, 1, 2'b01, 0);                                  // 28 still held
    add(1, 1, 0, 0, 1, 0, 2'b00, 0);                                  // 29 ack IRQ
    add(1, 1, 0, 1, 0, 0, 2'b00, 0);                                  // 30 nothing
    add(0, 0, 0, 0, 0, 0, 2'b00, 0);                                  // 31 both fall
    add(0, 0, 0, 0, 0, 0, 2'b00, 0);                                  // 32
    add(0, 0, 0, 0, 0, 0, 2'b00, 1);                                  // 33 latch set
    add(0, 0, 0, 1, 0, 1, 2'b10, 1);                                  // 34 NMI beats IRQ
    add(1, 0, 0, 0, 1, 0, 2'b00, 0);                                  // 35 ack NMI
    add(1, 0, 0, 1, 0, 1, 2'b01, 0);                                  // 36 IRQ next
    add(1, 1, 0, 0, 1, 0, 2'b00, 0);                                  // 37 ack IRQ
    add(1, 1, 0, 0, 0, 0, 2'b00, 0);                                  // 38
    add(0, 1, 0, 0, 0, 0, 2'b00, 0);                                  // 39 nmi falls
    add(0, 1, 0, 0, 0, 0, 2'b00, 0);                                  // 40
    add(0, 1, 0, 0, 0, 0, 2'b00, 1);                                  // 41 latch set
    add(0, 1, 0, 1, 0, 1, 2'b10, 1);                                  // 42 NMI presented
    add(1, 1, 0, 0, 0, 1, 2'b10, 1);                                  // 43 nmi rises
    add(1, 1, 0, 0, 0, 1, 2'b10, 1);                                  // 44
    add(0, 1, 0, 0, 0, 1, 2'b10, 1);                                  // 45 second fall
    add(0, 0, 0, 0, 0, 1, 2'b10, 1);                                  // 46 irq falls too
    add(0, 0, 0, 0, 1, 0, 2'b00, 1);                                  // 47 ack + new edge: stays set
    add(0, 0, 0, 1, 0, 1, 2'b10, 1);                                  // 48 NMI again over IRQ
    add(0, 0, 0, 1, 1, 0, 2'b00, 0);                                  // 49 ack+boundary: no new presentation
    add(0, 0, 0, 1, 0, 1, 2'b01, 0);                                  // 50 IRQ now
    add(1, 1, 0, 0, 1, 0, 2'b00, 0);                                  // 51 ack IRQ
    add(1, 1, 0, 0, 1, 0, 2'b00, 0);                                  // 52 stray ack ignored

    // Reset state
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b0, 2'b00, 1'b0);
    $display("reset: pending=%0d type=%b vec=%h", int_pending, int_type, vector_addr);
    rst = 1'b0;

    foreach (vecs[i]) begin
      nmi_n = vecs[i].nmi_n; irq_n = vecs[i].irq_n; P_I = vecs[i].p_i;
      insn_boundary = vecs[i].bnd; int_ack = vecs[i].ack;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("row%0d", i + 1), vecs[i].exp_pend, vecs[i].exp_type, vecs[i].exp_latch);
      $display("row %0d: nmi_n=%b irq_n=%b P_I=%b bnd=%b ack=%b -> pend=%b type=%b vec=%h latch=%b",
               i + 1, nmi_n, irq_n, P_I, insn_boundary, int_ack,
               int_pending, int_type, vector_addr, nmi_latch);
    end

    // Async reset while an NMI is presented
    idle_inputs();
    nmi_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    insn_boundary = 1'b1;
    @(posedge clk);
    @(negedge clk);
    insn_boundary = 1'b0;
    chk_all("pre_rst_nmi", 1'b1, 2'b10, 1'b1);
    $display("pre-reset: pend=%b type=%b vec=%h latch=%b", int_pending, int_type, vector_addr, nmi_latch);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 2'b00, 1'b0);
    $display("async reset: pend=%b type=%b vec=%h latch=%b", int_pending, int_type, vector_addr, nmi_latch);
    @(negedge clk);
    rst = 1'b0;
    nmi_n = 1'b1;
    for (int e = 1; e <= RESET_DELAY; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rewait%0d.pending", e), {15'd0, int_pending}, 16'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk_all("rereset", 1'b1, 2'b11, 1'b0);
    $display("re-reset after %0d edges: pend=%b type=%b vec=%h", RESET_DELAY + 1, int_pending, int_type, vector_addr);
    int_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    int_ack = 1'b0;
    chk_all("rereset_ack", 1'b0, 2'b00, 1'b0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk_all("no_rerequest", 1'b0, 2'b00, 1'b0);
    $display("after reset ack: pend=%b type=%b", int_pending, int_type);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_nmi_seq.md
Name: irq_nmi_seq

Overview:
- Interrupt/reset request sequencer directly upstream of the CPU control state machine.
- Synchronizes the external /NMI and /IRQ pins and latches the NMI falling edge.
- Masks IRQ with the P register I flag and arbitrates RESET > NMI > IRQ.
- Presents one registered request, with its vector address and pushed-B value, to the control unit at instruction boundaries; holds it until the control unit acknowledges.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on nmi_n and irq_n; minimum 2.
- RESET_DELAY, 7: clk cycles after rst deassertion before the RESET request is presented; range 0..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- nmi_n  in  1  external NMI pin, asynchronous, active low, edge-sensitive.
- irq_n  in  1  external IRQ pin, asynchronous, active low, level-sensitive.
- P_I  in  1  interrupt-disable flag (P_in[2]) from the status register.
- insn_boundary  in  1  control pulses high in the cycle it would fetch the next opcode.
- int_ack  in  1  one-cycle pulse; control has begun servicing the presented request.
- int_pending  out  1  a request is presented.
- int_type  out  2  00 none, 01 IRQ, 10 NMI, 11 RESET.
- vector_addr  out  16  FFFC for RESET, FFFA for NMI, FFFE for IRQ or none.
- push_B  out  1  B bit for the pushed P; always 0 (hardware source); BRK is handled in control.
- nmi_latch  out  1  pending NMI edge (debug/visibility).

Behaviour:
- Reset (async assert):
  - All synchronizer flops = 1; nmi_prev = 1; nmi_latch = 0.
  - int_pending = 0, int_type = 00, vector_addr = FFFE, push_B = 0.
  - reset_cnt = 0; rst_req = 1.
- Reset release: reset_cnt increments each cycle until it equals RESET_DELAY. When reset_cnt == RESET_DELAY, RESET is eligible, independent of insn_boundary. RESET_DELAY = 0 means eligible on the first edge after release.
- RESET presentation: the next edge after RESET becomes eligible latches int_pending = 1, int_type = 11, vector_addr = FFFC.
  - rst_req clears only on int_ack while int_type == 11.
  - While rst_req = 1, NMI edges still latch but are not presented; IRQ is ignored.
- Synchronizers:
  - The SYNC_STAGES chain produces nmi_s and irq_s.
  - nmi_prev registers nmi_s.
  - Edge condition is nmi_prev == 1 and nmi_s == 0.
  - A falling nmi_n sampled at edge k sets nmi_latch at edge k+SYNC_STAGES.
- nmi_latch:
  - Set on the edge condition.
  - Cleared on int_ack while int_type == 10.
  - If a new edge occurs in the same cycle as that ack, set wins and the latch stays 1.
  - Multiple edges before service merge into one request.
- irq_active = (irq_s == 0) and (P_I == 0). It is not latched: if irq_n rises before a boundary, no IRQ is taken.
- Arbitration: when int_pending = 0, insn_boundary = 1 and rst_req = 0:
  - nmi_latch = 1 presents NMI (10, FFFA).
  - Otherwise irq_active presents IRQ (01, FFFE).
  - Otherwise outputs stay idle.
  - Outputs are registered; visible the cycle after the boundary.
- Hold: while int_pending = 1, int_type and vector_addr are frozen. New NMI edges only set nmi_latch. A higher-priority arrival does not preempt a presented request.
- Ack:
  - int_ack with int_pending = 1 clears int_pending and sets int_type = 00 on the next edge; vector_addr returns to FFFE.
  - int_ack with int_pending = 0 is ignored.
  - int_ack and insn_boundary in the same cycle: the ack is processed; no new presentation that cycle.
- IRQ withdrawal after presentation: IRQ stays presented until ack; the 6502 commits once sequencing begins.
- Async rst mid-request: everything returns to reset values immediately, and the RESET_DELAY count restarts on release.
- States: RST_WAIT (counting), IDLE, PRESENTED. Transitions:
  - RST_WAIT to PRESENTED on count done.
  - IDLE to PRESENTED on boundary with a request.
  - PRESENTED to IDLE on int_ack.

Test Plan:
- RESET_DELAY=7, release rst at edge 0, never ack: int_type=11, vector_addr=FFFC after edge 8. Pulse int_ack: int_type=00 next edge. No re-request.
- After reset service, nmi_n low at edge 10, held low, boundary pulses at edges 14 and 20: nmi_latch=1 after edge 12. int_type=10, vector_addr=FFFA after edge 14. Ack at 15 clears it. Boundary 20 presents nothing (level held, no new edge).
- irq_n low, P_I=1, boundary: no request. Set P_I=0, boundary: int_type=01, FFFE. Raise irq_n before ack: request remains until int_ack.
- IRQ active and NMI latched at the same boundary: NMI presented first. After ack, the next boundary presents IRQ.
- NMI presented, second nmi_n fall arriving in the ack cycle: after ack, nmi_latch=1. The next boundary presents NMI again.
- Assert rst while int_type=10: all outputs are at reset values immediately. nmi_latch=0. FFFC is presented RESET_DELAY+1 cycles after release.
